axil_cmd_master: RTL
====================

Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite initiator. It converts a simple command/response handshake from CL logic into single-beat AXI-Lite reads and writes.
- It is the master-side counterpart to the OCL register slaves used across CL examples. It drives a register slave, such as a URAM control register, from internal sequencers and self-test logic.
- It has a per-transaction watchdog so that a hung slave cannot stall the requester.

Parameters:
- ADDR_W, 32, AXI-Lite address width.
- TIMEOUT_CYCLES, 1024, cycles allowed from command accept to B/R handshake; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_wr  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  32  read data (0 for writes).
- rsp_resp  out  2  AXI response code.
- rsp_timeout  out  1  transaction ended by watchdog.
- m_awvalid/m_awready/m_awaddr  out/in/out  1/1/ADDR_W  AW channel.
- m_wvalid/m_wready/m_wdata/m_wstrb  out/in/out/out  1/1/32/4  W channel.
- m_bvalid/m_bready/m_bresp  in/out/in  1/1/2  B channel.
- m_arvalid/m_arready/m_araddr  out/in/out  1/1/ADDR_W  AR channel.
- m_rvalid/m_rready/m_rdata/m_rresp  in/out/in/in  1/1/32/2  R channel.

Behaviour:
- Reset values (async assert, sync deassert assumed upstream): state=IDLE, all m_*valid=0, all m_*ready=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, watchdog=0.
- All AXI outputs are driven from flops: no combinational path from any AXI input to any AXI output.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture addr, wdata, wstrb and wr. Next state is WR_REQ (awvalid=wvalid=1) or RD_REQ (arvalid=1).
  - The watchdog clears on accept.
  - The first AXI valid is asserted the cycle after accept.
- WR_REQ:
  - AW and W are independent. Each valid drops the cycle after its own handshake.
  - The order may be AW first, W first or simultaneous; address and data are never re-issued.
  - Once both handshakes complete, go to WR_RESP with bready=1.
- WR_RESP: on bvalid&bready, latch bresp into rsp_resp, set rsp_rdata=0, go to RSP.
- RD_REQ: arvalid held until arready. On handshake go to RD_RESP with rready=1.
- RD_RESP: on rvalid&rready, latch rdata and rresp, go to RSP.
- RSP:
  - rsp_valid=1. Outputs are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, return to IDLE.
  - cmd_ready=0 throughout RSP; there is no back-to-back bypass.
- Watchdog:
  - Counts every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP, saturating.
  - When the count reaches TIMEOUT_CYCLES:
    - deassert every m_*valid and m_*ready;
    - set rsp_resp=2'b10 (SLVERR), rsp_rdata=32'hDEAD_DEAD, rsp_timeout=1;
    - go to RSP;
    - set the sticky flag drain_b (write) or drain_r (read).
  - A handshake completing in the same cycle as expiry takes priority, so the normal response is returned.
- Drain:
  - While drain_b or drain_r is set, bready or rready stays 1 in every state.
  - A late B/R beat is consumed and discarded, then the corresponding drain flag clears.
  - IDLE does not accept a new command of the same direction until the drain flag clears.
  - A late beat is never reported as a response.
- Unrecognised bresp/rresp codes (01, 11) are passed through unchanged.
- Reset mid-transaction: all valids drop immediately (async). The pending command and any drain state are lost.

Test Plan:
- Write with addr=0x500, wdata=0x1234_5678, wstrb=0xF; slave gives awready and wready the same cycle and bvalid 2 cycles later with bresp=0 -> AW/W asserted 1 cycle after accept, each dropped after its handshake; rsp_valid with resp=0, rdata=0, timeout=0.
- Write where the slave holds awready=0 for 5 cycles but wready=1 immediately -> wvalid drops after 1 beat; awvalid held with a stable address; exactly one W beat is issued; the response is returned normally.
- Read addr=0x500; slave gives arready after 3 cycles and rvalid with rdata=0xA000_0005, rresp=0 -> rsp_rdata=0xA000_0005; rsp held while rsp_ready=0 for 4 cycles; cmd_ready=0 until rsp_ready.
- Read with TIMEOUT_CYCLES=16 and the slave never asserting rvalid -> at cycle 16 after accept, rsp_resp=2'b10, rdata=0xDEAD_DEAD, timeout=1. A later rvalid is drained with no rsp_valid; a new read is blocked until that drain completes.
- Slave returns bresp=2'b10 -> rsp_resp=2'b10, timeout=0.
- Assert rst while awvalid=1 -> awvalid, wvalid and cmd_ready go to 0 asynchronously. After release, cmd_ready=1 on the first clock and a fresh write completes normally.

Source files
------------

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI-Lite read or write out, one response back.
// First AXI valid one cycle after accept; cmd_ready low from accept until the response is taken; watchdog bounds the wait.
module axil_cmd_master #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   input  logic [3:0]        cmd_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic              rsp_timeout,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic              m_wvalid,
   input  logic              m_wready,
   output logic [31:0]       m_wdata,
   output logic [3:0]        m_wstrb,
   input  logic              m_bvalid,
   output logic              m_bready,
   input  logic [1:0]        m_bresp,
   output logic              m_arvalid,
   input  logic              m_arready,
   output logic [ADDR_W-1:0] m_araddr,
   input  logic              m_rvalid,
   output logic              m_rready,
   input  logic [31:0]       m_rdata,
   input  logic [1:0]        m_rresp
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] WDOG_MAX  = '1;

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
   } state_t;

   state_t            state_q, state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              arvalid_q, arvalid_d;
   logic              bready_q, bready_d;
   logic              rready_q, rready_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        rsp_resp_q, rsp_resp_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [CNT_W-1:0]  wdog_q, wdog_d;
   logic              drain_b_q, drain_b_d;
   logic              drain_r_q, drain_r_d;

   logic cmd_fire;
   logic b_hs;
   logic r_hs;
   logic expire;
   logic take_timeout;

   // A direction with a late beat still outstanding is held off so the stray beat cannot be mistaken for a response.
   assign cmd_ready = cmd_ready_q & ~(cmd_wr ? drain_b_q : drain_r_q);
   assign cmd_fire  = cmd_valid & cmd_ready;
   assign b_hs      = m_bvalid & bready_q;
   assign r_hs      = m_rvalid & rready_q;
   assign expire    = (TIMEOUT_CYCLES != 0) && (wdog_q >= WDOG_LAST);

   always_comb begin
      state_d       = state_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      arvalid_d     = arvalid_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;
      wdog_d        = wdog_q;
      drain_b_d     = drain_b_q & ~b_hs;
      drain_r_d     = drain_r_q & ~r_hs;
      take_timeout  = 1'b0;

      if ((state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) && (wdog_q != WDOG_MAX)) begin
         wdog_d = wdog_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               wdog_d  = '0;
               if (cmd_wr) begin
                  state_d   = WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = RD_REQ;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR_REQ: begin
            if (m_awready) awvalid_d = 1'b0;
            if (m_wready)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               state_d = WR_RESP;
            end else if (expire) begin
               take_timeout = 1'b1;
            end
         end
         WR_RESP: begin
            if (b_hs) begin
               rsp_resp_d    = m_bresp;
               rsp_rdata_d   = 32'h0;
               rsp_timeout_d = 1'b0;
               state_d       = RSP;
            end else if (expire) begin
               take_timeout = 1'b1;
            end
         end
         RD_REQ: begin
            if (m_arready) begin
               arvalid_d = 1'b0;
               state_d   = RD_RESP;
            end else if (expire) begin
               take_timeout = 1'b1;
            end
         end
         RD_RESP: begin
            if (r_hs) begin
               rsp_resp_d    = m_rresp;
               rsp_rdata_d   = m_rdata;
               rsp_timeout_d = 1'b0;
               state_d       = RSP;
            end else if (expire) begin
               take_timeout = 1'b1;
            end
         end
         RSP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (take_timeout) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         arvalid_d     = 1'b0;
         rsp_resp_d    = 2'b10;
         rsp_rdata_d   = 32'hDEAD_DEAD;
         rsp_timeout_d = 1'b1;
         state_d       = RSP;
         if (state_q inside {WR_REQ, WR_RESP}) drain_b_d = 1'b1;
         else                                  drain_r_d = 1'b1;
      end

      // Drain keeps the response channel open in every state until the abandoned beat shows up.
      bready_d    = (state_d == WR_RESP) | drain_b_d;
      rready_d    = (state_d == RD_RESP) | drain_r_d;
      cmd_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RSP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         bready_q      <= 1'b0;
         rready_q      <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= '0;
         rsp_timeout_q <= 1'b0;
         wdog_q        <= '0;
         drain_b_q     <= 1'b0;
         drain_r_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         arvalid_q     <= arvalid_d;
         bready_q      <= bready_d;
         rready_q      <= rready_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
         wdog_q        <= wdog_d;
         drain_b_q     <= drain_b_d;
         drain_r_q     <= drain_r_d;
      end
   end

   assign m_awvalid   = awvalid_q;
   assign m_awaddr    = addr_q;
   assign m_wvalid    = wvalid_q;
   assign m_wdata     = wdata_q;
   assign m_wstrb     = wstrb_q;
   assign m_bready    = bready_q;
   assign m_arvalid   = arvalid_q;
   assign m_araddr    = addr_q;
   assign m_rready    = rready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_resp    = rsp_resp_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule
